// File: rtl/label_pkg.sv
// label_pkg: shared constants and types for the label RAM path.
//   LABEL_ADDR_W / LABEL_DATA_W / LABEL_NREQ : default label RAM geometry and reader count
//   label_wr_t                               : one queued label write, {addr, data}
package label_pkg;

    localparam int unsigned LABEL_ADDR_W = 8;
    localparam int unsigned LABEL_DATA_W = 8;
    localparam int unsigned LABEL_NREQ   = 4;

    typedef struct packed {
        logic [LABEL_ADDR_W-1:0] addr;
        logic [LABEL_DATA_W-1:0] data;
    } label_wr_t;

endpackage

// File: rtl/label_wfifo.sv
// label_wfifo: synchronous FIFO holding pending label RAM writes.
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset (empties the queue)
//   push, push_data : enqueue one entry; ignored while full
//   pop             : dequeue the head; ignored while empty
//   head            : oldest entry (valid while !empty)
//   level           : registered entry count, one bit wider than the pointers
//   full, empty     : decoded from level
module label_wfifo
    import label_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = label_wr_t
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read below level.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/label_ram_arbiter.sv
// label_ram_arbiter: shares the single-port label RAM between NREQ display readers and a
// queued write stream. Reads win with fixed priority (lowest index); queued writes drain
// one per cycle only when no reader is requesting.
// Optional feature macro: LABEL_ARB_COLLISION_CNT_EN enables the saturating collision
// counter on coll_cnt; without it coll_cnt is tied to 0.
// Ports:
//   px_clk, rstn                   : pixel clock, asynchronous active-low reset
//   rd_req, rd_addr                : per-reader request and packed addresses
//   rd_gnt                         : combinational one-hot grant
//   rd_valid, rd_id, rd_data       : read response one cycle after the grant
//   wr_valid, wr_addr, wr_data     : write stream in; wr_ready / wr_level report the queue
//   ram_addr, ram_we, ram_din      : label RAM command
//   ram_dout                       : label RAM read data (1-cycle synchronous)
//   coll_cnt                       : read collision count
module label_ram_arbiter
    import label_pkg::*;
#(
    parameter int unsigned NREQ        = LABEL_NREQ,
    parameter int unsigned ADDR_W      = LABEL_ADDR_W,
    parameter int unsigned DATA_W      = LABEL_DATA_W,
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic                          px_clk,
    input  logic                          rstn,
    input  logic [NREQ-1:0]               rd_req,
    input  logic [NREQ*ADDR_W-1:0]        rd_addr,
    output logic [NREQ-1:0]               rd_gnt,
    output logic                          rd_valid,
    output logic [$clog2(NREQ)-1:0]       rd_id,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic [$clog2(WFIFO_DEPTH):0]  wr_level,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_din,
    input  logic [DATA_W-1:0]             ram_dout,
    output logic [7:0]                    coll_cnt
);

    localparam int unsigned ID_W = $clog2(NREQ);

    // Same {addr, data} layout as label_wr_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wr_entry_t          wq_in;
    wr_entry_t          wq_head;
    logic               wq_full;
    logic               wq_empty;
    logic               wq_push;
    logic               wq_pop;

    logic               any_req;
    logic               found;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  win_addr;

    // ---------------------------------------------------------------- write queue
    assign wr_ready = !wq_full;
    assign wq_push  = wr_valid && wr_ready;
    assign wq_in    = '{addr: wr_addr, data: wr_data};
    assign wq_pop   = !any_req && !wq_empty;

    label_wfifo #(
        .DEPTH   (WFIFO_DEPTH),
        .entry_t (wr_entry_t)
    ) u_wfifo (
        .clk       (px_clk),
        .rstn      (rstn),
        .push      (wq_push),
        .push_data (wq_in),
        .pop       (wq_pop),
        .head      (wq_head),
        .level     (wr_level),
        .full      (wq_full),
        .empty     (wq_empty)
    );

    // ---------------------------------------------------------------- read arbitration
    assign any_req = |rd_req;

    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_addr = '0;
        rd_gnt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_req[i] && !found) begin
                found     = 1'b1;
                win_id    = ID_W'(i);
                win_addr  = rd_addr[i*ADDR_W +: ADDR_W];
                rd_gnt[i] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- RAM port mux
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (any_req) begin
            ram_addr = win_addr;
        end else if (wq_pop) begin
            ram_addr = wq_head.addr;
            ram_din  = wq_head.data;
            ram_we   = 1'b1;
        end
    end

    // ---------------------------------------------------------------- read response
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rd_id    <= '0;
        end else begin
            rd_valid <= any_req;
            rd_id    <= win_id;
        end
    end

    // RAM read data already lines up with the registered tag.
    assign rd_data = ram_dout;

    // ---------------------------------------------------------------- collision counter
`ifdef LABEL_ARB_COLLISION_CNT_EN
    logic coll;

    // More than one request bit set: clearing the lowest set bit leaves something.
    assign coll = |(rd_req & (rd_req - NREQ'(1)));

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            coll_cnt <= 8'd0;
        end else if (coll && (coll_cnt != 8'hFF)) begin
            coll_cnt <= coll_cnt + 8'd1;
        end
    end
`else
    assign coll_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_label_ram_arbiter.sv
// Testbench for label_ram_arbiter: directed stimulus, scoreboarded read responses and
// RAM writes, plus direct checks of grants, queue status and reset behaviour.
module tb_label_ram_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic                   px_clk = 1'b0;
    logic                   rstn   = 1'b0;
    logic [NREQ-1:0]        rd_req;
    logic [NREQ*ADDR_W-1:0] rd_addr;
    logic [NREQ-1:0]        rd_gnt;
    logic                   rd_valid;
    logic [1:0]             rd_id;
    logic [DATA_W-1:0]      rd_data;
    logic                   wr_valid;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_ready;
    logic [2:0]             wr_level;
    logic [ADDR_W-1:0]      ram_addr;
    logic                   ram_we;
    logic [DATA_W-1:0]      ram_din;
    logic [DATA_W-1:0]      ram_dout = '0;
    logic [7:0]             coll_cnt;

    always #5 px_clk = ~px_clk;

    label_ram_arbiter #(
        .NREQ        (NREQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WFIFO_DEPTH (DEPTH)
    ) dut (
        .px_clk   (px_clk),
        .rstn     (rstn),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .wr_level (wr_level),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .coll_cnt (coll_cnt)
    );

    // Label RAM: synchronous read-first single port.
    logic [DATA_W-1:0] mem [256];
    always @(posedge px_clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } rd_exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    rd_exp_t rq[$];
    wr_exp_t wq[$];
    rd_exp_t re;
    wr_exp_t we_e;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge px_clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read response or a RAM write.
    always @(negedge px_clk) begin
        if (rd_valid) begin
            if (rq.size() == 0) begin
                chk("rd_unexpected", {31'd0, rd_valid}, 32'd0);
            end else begin
                re = rq.pop_front();
                chk("rd_id", {30'd0, rd_id}, {30'd0, re.id});
                chk("rd_data", {24'd0, rd_data}, {24'd0, re.data});
            end
        end
        if (ram_we) begin
            if (wq.size() == 0) begin
                chk("ram_we_unexpected", {31'd0, ram_we}, 32'd0);
            end else begin
                we_e = wq.pop_front();
                chk("ram_wr_addr", {24'd0, ram_addr}, {24'd0, we_e.addr});
                chk("ram_wr_data", {24'd0, ram_din}, {24'd0, we_e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'h11;
        mem[8'h0A] = 8'h62;
        mem[8'h17] = 8'h41;
        mem[8'h33] = 8'h7E;

        rd_req   = '0;
        rd_addr  = {8'h33, 8'h17, 8'h0A, 8'h05};
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rstn     = 1'b0;

        // Reset state
        neg();
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_id", {30'd0, rd_id}, 32'd0);
        chk("rst_wr_level", {29'd0, wr_level}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_coll_cnt", {24'd0, coll_cnt}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        tick();
        rstn = 1'b1;

        // Idle cycle
        neg();
        chk("idle_ram_addr", {24'd0, ram_addr}, 32'd0);
        chk("idle_ram_we", {31'd0, ram_we}, 32'd0);
        chk("idle_ram_din", {24'd0, ram_din}, 32'd0);
        chk("idle_rd_gnt", {28'd0, rd_gnt}, 32'd0);

        // Single read from requester 2
        tick();
        rd_req = 4'b0100;
        rq.push_back('{id: 2'd2, data: 8'h41});
        neg();
        chk("single_gnt", {28'd0, rd_gnt}, 32'h4);
        chk("single_ram_addr", {24'd0, ram_addr}, 32'h17);
        chk("single_ram_we", {31'd0, ram_we}, 32'd0);
        tick();
        rd_req = '0;
        neg();
        chk("single_rd_valid", {31'd0, rd_valid}, 32'd1);

        // Collision: requesters 1 and 3
        tick();
        rd_req = 4'b1010;
        rq.push_back('{id: 2'd1, data: 8'h62});
        neg();
        chk("coll_gnt", {28'd0, rd_gnt}, 32'h2);
        chk("coll_ram_addr", {24'd0, ram_addr}, 32'h0A);
        tick();
        rd_req = '0;
        neg();
`ifdef LABEL_ARB_COLLISION_CNT_EN
        chk("coll_cnt", {24'd0, coll_cnt}, 32'd1);
`else
        chk("coll_cnt", {24'd0, coll_cnt}, 32'd0);
`endif

        // Fill the write queue while reads are continuous
        tick();
        rd_req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1;
            wr_addr  = 8'h80 + 8'(k);
            wr_data  = 8'hC0 + 8'(k);
            rq.push_back('{id: 2'd0, data: 8'h11});
            if (k < 4) wq.push_back('{addr: 8'h80 + 8'(k), data: 8'hC0 + 8'(k)});
            neg();
            chk("fill_wr_ready", {31'd0, wr_ready}, (k < 4) ? 32'd1 : 32'd0);
            chk("fill_gnt", {28'd0, rd_gnt}, 32'h1);
            tick();
        end
        wr_valid = 1'b0;
        rq.push_back('{id: 2'd0, data: 8'h11});
        neg();
        chk("full_wr_level", {29'd0, wr_level}, 32'd4);
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("full_ram_we", {31'd0, ram_we}, 32'd0);

        // Reads stop: four back-to-back drains
        tick();
        rd_req = '0;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("drain_ram_we", {31'd0, ram_we}, 32'd1);
            tick();
        end
        neg();
        chk("drained_ram_we", {31'd0, ram_we}, 32'd0);
        chk("drained_wr_level", {29'd0, wr_level}, 32'd0);
        chk("drained_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Push and pop in the same cycle at level 2
        tick();
        rd_req   = 4'b0001;
        wr_valid = 1'b1;
        wr_addr  = 8'h90;
        wr_data  = 8'hD0;
        rq.push_back('{id: 2'd0, data: 8'h11});
        wq.push_back('{addr: 8'h90, data: 8'hD0});
        tick();
        wr_addr = 8'h91;
        wr_data = 8'hD1;
        rq.push_back('{id: 2'd0, data: 8'h11});
        wq.push_back('{addr: 8'h91, data: 8'hD1});
        tick();
        rd_req  = '0;
        wr_addr = 8'h92;
        wr_data = 8'hD2;
        wq.push_back('{addr: 8'h92, data: 8'hD2});
        neg();
        chk("pp_level_before", {29'd0, wr_level}, 32'd2);
        chk("pp_ram_we", {31'd0, ram_we}, 32'd1);
        chk("pp_ram_addr", {24'd0, ram_addr}, 32'h90);
        tick();
        wr_valid = 1'b0;
        neg();
        chk("pp_level_after", {29'd0, wr_level}, 32'd2);
        tick();
        neg();
        chk("pp_level_drain1", {29'd0, wr_level}, 32'd1);
        tick();
        neg();
        chk("pp_level_drain2", {29'd0, wr_level}, 32'd0);

        // Write then read the same address
        tick();
        wr_valid = 1'b1;
        wr_addr  = 8'h10;
        wr_data  = 8'h55;
        wq.push_back('{addr: 8'h10, data: 8'h55});
        neg();
        chk("wtr_no_same_cycle_we", {31'd0, ram_we}, 32'd0);
        tick();
        wr_valid = 1'b0;
        neg();
        chk("wtr_drain_we", {31'd0, ram_we}, 32'd1);
        tick();
        rd_req        = 4'b0001;
        rd_addr[7:0]  = 8'h10;
        rq.push_back('{id: 2'd0, data: 8'h55});
        neg();
        chk("wtr_ram_addr", {24'd0, ram_addr}, 32'h10);
        tick();
        rd_req       = '0;
        rd_addr[7:0] = 8'h05;
        neg();

        // Reset with three queued writes and a read in flight
        tick();
        rd_req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_addr  = 8'hA0 + 8'(k);
            wr_data  = 8'hE0 + 8'(k);
            rq.push_back('{id: 2'd0, data: 8'h11});
            tick();
        end
        wr_valid = 1'b0;
        // This read's response is killed by the reset below.
        neg();
        chk("mid_wr_level", {29'd0, wr_level}, 32'd3);
        tick();
        rstn   = 1'b0;
        rd_req = '0;
        #1;
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_wr_level", {29'd0, wr_level}, 32'd0);
        chk("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
        neg();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("post_rst_ram_we", {31'd0, ram_we}, 32'd0);
            chk("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
            tick();
        end

        // Every expected response must have been observed
        neg();
        chk("rd_queue_empty", rq.size(), 32'd0);
        chk("wr_queue_empty", wq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
